// File: rtl/switch_scan_debounce_pkg.sv
// switch_scan_debounce_pkg -- constants shared by the switch scan front end and the change detector.
// Rev 1.0
`default_nettype none

package switch_scan_debounce_pkg;

  localparam int C_NUM_SW    = 10;
  localparam int C_SCAN_W    = 4;
  localparam int C_DB_CYCLES = 50000;
  localparam int C_DB_CNT_W  = 16;

  typedef enum logic [1:0] {
    SW_UNCHANGE = 2'b00,
    SW_UP       = 2'b01,
    SW_DOWN     = 2'b10
  } sw_change_e;

  typedef logic [C_SCAN_W-1:0] scan_idx_t;

  function automatic scan_idx_t scan_next(input scan_idx_t cur, input int num_sw);
    return (cur == scan_idx_t'(num_sw - 1)) ? '0 : cur + scan_idx_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_scan_debounce_if.sv
// switch_scan_debounce_if -- raw switch input plus debounced/history/scan outputs.
// Rev 1.0
`default_nettype none

interface switch_scan_debounce_if
  import switch_scan_debounce_pkg::*;
#(
  parameter int NUM_SW = C_NUM_SW
);

  logic [NUM_SW-1:0]   SW_RAW;
  logic [NUM_SW-1:0]   SW;
  logic [NUM_SW-1:0]   SW_HISTORY;
  logic [C_SCAN_W-1:0] SCAN_COUNTER;
  logic                SCAN_WRAP;

  modport master (
    input  SW_RAW,
    output SW,
    output SW_HISTORY,
    output SCAN_COUNTER,
    output SCAN_WRAP
  );

  modport slave (
    output SW_RAW,
    input  SW,
    input  SW_HISTORY,
    input  SCAN_COUNTER,
    input  SCAN_WRAP
  );

endinterface

`default_nettype wire

// File: rtl/switch_scan_debounce_cell.sv
// sw_debounce_cell -- 2-FF synchroniser plus stable-count debouncer for one switch.
// Rev 1.0
`default_nettype none

module sw_debounce_cell
  import switch_scan_debounce_pkg::*;
#(
  parameter int DB_CYCLES = C_DB_CYCLES,
  parameter int DB_CNT_W  = C_DB_CNT_W
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw_i,
  output logic stable_o
);

  logic                s1_q;
  logic                s2_q;
  logic                stable_q;
  logic                stable_d;
  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;

  // Any cycle where the synchronised level agrees with stable restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == DB_CNT_W'(DB_CYCLES - 1)) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

`default_nettype wire

// File: rtl/switch_scan_debounce.sv
// switch_scan_debounce -- debounced switches, per-switch history commit and free-running scan index.
// Rev 1.0
`default_nettype none

module switch_scan_debounce
  import switch_scan_debounce_pkg::*;
#(
  parameter int NUM_SW    = C_NUM_SW,
  parameter int DB_CYCLES = C_DB_CYCLES,
  parameter int DB_CNT_W  = C_DB_CNT_W
) (
  input  logic                   CLK,
  input  logic                   RESET,
  switch_scan_debounce_if.master bus
);

  logic [NUM_SW-1:0] sw_stable;
  logic [NUM_SW-1:0] sw_dly_q;
  logic [NUM_SW-1:0] hist_q;
  logic [NUM_SW-1:0] hist_d;
  scan_idx_t         scan_q;
  scan_idx_t         scan_d;
  logic              wrap_q;

  generate
    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_cell
      sw_debounce_cell #(
        .DB_CYCLES (DB_CYCLES),
        .DB_CNT_W  (DB_CNT_W)
      ) u_cell (
        .CLK      (CLK),
        .RESET    (RESET),
        .raw_i    (bus.SW_RAW[gi]),
        .stable_o (sw_stable[gi])
      );
    end
  endgenerate

  // Commit the one-cycle-old level: that is what the consumer compared during this slot,
  // so a later SW change stays pending until the next visit.
  always_comb begin
    scan_d = scan_next(scan_q, NUM_SW);
    hist_d = hist_q;
    for (int i = 0; i < NUM_SW; i++) begin
      if (scan_q == scan_idx_t'(i)) begin
        hist_d[i] = sw_dly_q[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scan_q   <= '0;
      wrap_q   <= 1'b0;
      sw_dly_q <= '0;
      hist_q   <= '0;
    end else begin
      scan_q   <= scan_d;
      wrap_q   <= (scan_d == scan_idx_t'(NUM_SW - 1));
      sw_dly_q <= sw_stable;
      hist_q   <= hist_d;
    end
  end

  assign bus.SW           = sw_stable;
  assign bus.SW_HISTORY   = hist_q;
  assign bus.SCAN_COUNTER = scan_q;
  assign bus.SCAN_WRAP    = wrap_q;

endmodule

`default_nettype wire
